// File: rtl/lift_car_door_ctrl.sv
// Car-side responder for the lift controller: models floor-to-floor travel and
// sequences the door open/hold/close cycle followed by a short guard interval.
module lift_car_door_ctrl #(
    parameter int N_FLOORS         = 12,
    parameter int TRAVEL_CYCLES    = 8,
    parameter int DOOR_OPEN_CYCLES = 16,
    parameter int GUARD_CYCLES     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_motion,
    input  logic                i_direction,
    input  logic                i_has_rqst_at_stopped_flr,
    input  logic                i_door_hold,
    output logic [N_FLOORS-1:0] o_flr_pos,
    output logic                o_door_open,
    output logic                o_limit_err
);

    localparam int IDX_W   = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int MAX_TD  = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
    localparam int MAX_CYC = (MAX_TD > GUARD_CYCLES) ? MAX_TD : GUARD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]    TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DOOR_LOAD   = CNT_W'(DOOR_OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0]    GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0]    TOP_IDX     = IDX_W'(N_FLOORS - 1);
    localparam logic [N_FLOORS-1:0] FLR_RESET   = N_FLOORS'(1);

    localparam logic [1:0] ST_AT_FLOOR = 2'd0;
    localparam logic [1:0] ST_TRAVEL   = 2'd1;
    localparam logic [1:0] ST_DOOR     = 2'd2;
    localparam logic [1:0] ST_GUARD    = 2'd3;

    logic [1:0]          state_q,    state_d;
    logic [IDX_W-1:0]    floor_q,    floor_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                dir_q,      dir_d;
    logic [N_FLOORS-1:0] flr_pos_q,  flr_pos_d;
    logic                door_q,     door_d;
    logic                err_q,      err_d;
    logic                move_legal;

    function automatic logic [N_FLOORS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_FLOORS-1:0] v;
        v = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (idx == IDX_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Saturating step keeps the index inside the shaft even if a bad move slipped through.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input logic up);
        logic [IDX_W-1:0] r;
        r = idx;
        if (up && (idx != TOP_IDX))
            r = idx + IDX_W'(1);
        else if (!up && (idx != '0))
            r = idx - IDX_W'(1);
        return r;
    endfunction

    assign move_legal = i_direction ? (floor_q != TOP_IDX) : (floor_q != '0);

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        flr_pos_d = flr_pos_q;
        door_d    = door_q;
        err_d     = 1'b0;

        case (state_q)
            ST_AT_FLOOR: begin
                if (i_has_rqst_at_stopped_flr) begin
                    state_d = ST_DOOR;
                    cnt_d   = DOOR_LOAD;
                    door_d  = 1'b1;
                end else if (i_motion) begin
                    if (move_legal) begin
                        state_d   = ST_TRAVEL;
                        dir_d     = i_direction;
                        cnt_d     = TRAVEL_LOAD;
                        flr_pos_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_TRAVEL: begin
                if (cnt_q == '0) begin
                    floor_d   = next_idx(floor_q, dir_q);
                    flr_pos_d = onehot(next_idx(floor_q, dir_q));
                    state_d   = ST_AT_FLOOR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // Hold is checked before expiry so an obstruction on the last cycle still keeps the door open.
            ST_DOOR: begin
                if (i_door_hold) begin
                    cnt_d = DOOR_LOAD;
                end else if (cnt_q == '0) begin
                    door_d  = 1'b0;
                    cnt_d   = GUARD_LOAD;
                    state_d = ST_GUARD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // Inputs are ignored here so the ALU's clear pulse lands before the request is sampled again.
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = ST_AT_FLOOR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_AT_FLOOR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_AT_FLOOR;
            floor_q   <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            flr_pos_q <= FLR_RESET;
            door_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            flr_pos_q <= flr_pos_d;
            door_q    <= door_d;
            err_q     <= err_d;
        end
    end

    assign o_flr_pos   = flr_pos_q;
    assign o_door_open = door_q;
    assign o_limit_err = err_q;

endmodule
